// File: rtl/bcd_down_timer.sv
// -----------------------------------------------------------------------------
// bcd_down_timer
//   Two-digit BCD countdown timer (99..00). While running, the count drops by
//   one every TICK_DIV clocks. Supports parallel BCD load, start/pause pulses
//   and a one-cycle end-of-count pulse. With WRAP=1 the last loaded value is
//   reloaded on the tick after reaching 00 and counting continues.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   start     in   pulse: begin (IDLE/DONE) or resume (PAUSE) counting
//   pause     in   pulse: suspend counting while running
//   load      in   pulse: load load_val (ignored while running)
//   load_val  in   [7:4] tens BCD, [3:0] ones BCD
//   q_tens    out  current tens digit
//   q_ones    out  current ones digit
//   running   out  high while counting
//   done      out  one-cycle pulse in the first cycle q shows 00
//   load_err  out  one-cycle pulse when a load with a non-BCD nibble is rejected
// -----------------------------------------------------------------------------
module bcd_down_timer #(
   parameter int TICK_DIV = 100000000,
   parameter bit WRAP     = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] q_tens,
   output logic [3:0] q_ones,
   output logic       running,
   output logic       done,
   output logic       load_err
);

   // A one-bit prescaler is kept even for TICK_DIV=1; it simply stays at 0.
   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [7:0]    rel_q, rel_d;
   logic [PW-1:0] pres_q, pres_d;
   logic          run_q, run_d;
   logic          done_q, done_d;
   logic          lerr_q, lerr_d;

   logic q_zero;
   logic ld_ok;

   assign q_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
   assign ld_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      rel_d   = rel_q;
      pres_d  = pres_q;
      done_d  = 1'b0;
      lerr_d  = 1'b0;

      if (state_q == S_RUN) begin
         // Loads and starts are ignored here; pause beats a simultaneous start.
         if (pause) begin
            state_d = S_PAUSE;
         end else if (pres_q == PMAX) begin
            pres_d = '0;
            if (q_zero) begin
               // Only reachable with WRAP=1: restart from the reload value.
               tens_d = rel_q[7:4];
               ones_d = rel_q[3:0];
            end else begin
               if (ones_q != 4'd0) begin
                  ones_d = ones_q - 4'd1;
               end else begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
               end
               // 01 is the only value whose decrement lands on 00.
               if (tens_q == 4'd0 && ones_q == 4'd1) begin
                  done_d = 1'b1;
                  if (!WRAP) state_d = S_DONE;
               end
            end
         end else begin
            pres_d = pres_q + PW'(1);
         end
      end else begin
         // IDLE, PAUSE, DONE: a load (valid or not) swallows any start.
         if (load) begin
            if (ld_ok) begin
               tens_d = load_val[7:4];
               ones_d = load_val[3:0];
               rel_d  = load_val;
               if (state_q == S_DONE) state_d = S_IDLE;
            end else begin
               lerr_d = 1'b1;
            end
         end else if (start && !q_zero) begin
            // Resuming from PAUSE keeps the partial prescaler count.
            if (state_q != S_PAUSE) pres_d = '0;
            state_d = S_RUN;
         end
      end

      run_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         rel_q   <= 8'h00;
         pres_q  <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         rel_q   <= rel_d;
         pres_q  <= pres_d;
         run_q   <= run_d;
         done_q  <= done_d;
         lerr_q  <= lerr_d;
      end
   end

   assign q_tens   = tens_q;
   assign q_ones   = ones_q;
   assign running  = run_q;
   assign done     = done_q;
   assign load_err = lerr_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

   localparam int TICK = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, pause = 1'b0, load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [3:0] t0, o0, t1, o1;
   logic       r0, dn0, le0, r1, dn1, le1;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model, index 0 = stop at 00, index 1 = wrap. Count kept as an integer.
   int m_val[2], m_rel[2], m_mode[2], m_pc[2];
   bit m_done[2], m_lerr[2];

   bcd_down_timer #(.TICK_DIV(TICK), .WRAP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load),
      .load_val(load_val), .q_tens(t0), .q_ones(o0), .running(r0),
      .done(dn0), .load_err(le0));

   bcd_down_timer #(.TICK_DIV(TICK), .WRAP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load),
      .load_val(load_val), .q_tens(t1), .q_ones(o1), .running(r1),
      .done(dn1), .load_err(le1));

   always #5 clk = ~clk;

   function automatic logic [10:0] obs(input int i);
      if (i == 0) return {t0, o0, r0, dn0, le0};
      return {t1, o1, r1, dn1, le1};
   endfunction

   function automatic logic [10:0] expv(input int i);
      logic [3:0] t, o;
      t = 4'(m_val[i] / 10);
      o = 4'(m_val[i] % 10);
      return {t, o, (m_mode[i] == M_RUN), m_done[i], m_lerr[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_rel[i] = 0; m_mode[i] = M_IDLE; m_pc[i] = 0;
         m_done[i] = 0; m_lerr[i] = 0;
      end
   endtask

   task automatic model_edge(input int i, input logic s, input logic p,
                             input logic l, input logic [7:0] lv);
      m_done[i] = 0;
      m_lerr[i] = 0;
      if (m_mode[i] == M_RUN) begin
         if (p) m_mode[i] = M_PAUSE;
         else begin
            m_pc[i]++;
            if (m_pc[i] == TICK) begin
               m_pc[i] = 0;
               if (m_val[i] == 0) m_val[i] = m_rel[i];
               else begin
                  m_val[i]--;
                  if (m_val[i] == 0) begin
                     m_done[i] = 1;
                     if (i == 0) m_mode[i] = M_DONE;
                  end
               end
            end
         end
      end else if (l) begin
         if (lv[7:4] < 4'd10 && lv[3:0] < 4'd10) begin
            m_val[i] = int'(lv[7:4]) * 10 + int'(lv[3:0]);
            m_rel[i] = m_val[i];
            if (m_mode[i] == M_DONE) m_mode[i] = M_IDLE;
         end else m_lerr[i] = 1;
      end else if (s && m_val[i] != 0) begin
         if (m_mode[i] != M_PAUSE) m_pc[i] = 0;
         m_mode[i] = M_RUN;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
   task automatic step(input logic s, input logic p, input logic l, input logic [7:0] lv);
      start = s; pause = p; load = l; load_val = lv;
      @(posedge clk);
      model_edge(0, s, p, l, lv);
      model_edge(1, s, p, l, lv);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00);
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      start = 0; pause = 0; load = 0;
      #2;
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs(i) !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state dut%0d got=%h want=000", i, obs(i));
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_countdown();
      int dcount = 0;
      do_reset();
      step(1, 0, 1, 8'h12);
      step(1, 0, 0, 8'h00);
      for (int k = 1; k <= 52; k++) begin
         step(0, 0, 0, 8'h00);
         if (dn0) dcount++;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
               n_err++;
               $display("FAIL countdown dut%0d k=%0d got=%h want=%h", i, k, obs(i), expv(i));
            end
         end
         if (k == 48) begin
            n_checks++;
            if ({t0, o0, dn0} !== 9'h001) begin
               n_err++;
               $display("FAIL countdown_at00 got=%h%h done=%b want=00 done=1", t0, o0, dn0);
            end
         end
      end
      n_checks++;
      if ({t0, o0, r0, dcount} !== {8'h00, 1'b0, 32'd1}) begin
         n_err++;
         $display("FAIL countdown_end q=%h%h run=%b dones=%0d want q=00 run=0 dones=1",
                  t0, o0, r0, dcount);
      end
   endtask

   task automatic test_load_err();
      logic [7:0] bad[2] = '{8'h3A, 8'hA3};
      do_reset();
      step(0, 0, 1, 8'h12);
      foreach (bad[j]) begin
         step(0, 0, 1, bad[j]);
         n_checks++;
         if ({t0, o0, le0} !== {8'h12, 1'b1} || obs(0) !== expv(0)) begin
            n_err++;
            $display("FAIL load_err_%h got q=%h%h err=%b want q=12 err=1", bad[j], t0, o0, le0);
         end
         step(0, 0, 0, 8'h00);
         n_checks++;
         if (le0 !== 1'b0) begin
            n_err++;
            $display("FAIL load_err_width got=%b want=0", le0);
         end
      end
      step(0, 0, 1, 8'h00);
      step(1, 0, 0, 8'h00);
      idle(2);
      n_checks++;
      if (r0 !== 1'b0 || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL start_at_00 running=%b want=0", r0);
      end
   endtask

   task automatic test_pause();
      do_reset();
      step(0, 0, 1, 8'h05);
      step(1, 0, 0, 8'h00);
      idle(6);
      step(0, 1, 0, 8'h00);
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 0, 8'h00);
         n_checks++;
         if ({t0, o0, r0} !== {8'h04, 1'b0} || obs(0) !== expv(0)) begin
            n_err++;
            $display("FAIL pause_freeze k=%0d got q=%h%h run=%b want q=04 run=0", k, t0, o0, r0);
         end
      end
      step(1, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      n_checks++;
      if ({t0, o0, r0} !== {8'h04, 1'b1}) begin
         n_err++;
         $display("FAIL resume_early got q=%h%h run=%b want q=04 run=1", t0, o0, r0);
      end
      step(0, 0, 0, 8'h00);
      n_checks++;
      if ({t0, o0} !== 8'h03 || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL resume_tick got q=%h%h want q=03", t0, o0);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] seq[$];
      logic [7:0] want[6] = '{8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00};
      int dcount = 0;
      int runlow = 0;
      do_reset();
      step(0, 0, 1, 8'h02);
      step(1, 0, 0, 8'h00);
      seq.push_back({t1, o1});
      for (int k = 1; k <= 22; k++) begin
         if (k == 3 || k == 10) step(0, 0, 1, (k == 3) ? 8'h55 : 8'hFF);
         else step(0, 0, 0, 8'h00);
         if ({t1, o1} !== seq[$]) seq.push_back({t1, o1});
         if (dn1) dcount++;
         if (!r1 || le1) runlow++;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
               n_err++;
               $display("FAIL wrap_model dut%0d k=%0d got=%h want=%h", i, k, obs(i), expv(i));
            end
         end
      end
      n_checks++;
      if (seq.size() != 6 || dcount != 2 || runlow != 0) begin
         n_err++;
         $display("FAIL wrap_summary changes=%0d dones=%0d badcycles=%0d want 6 2 0",
                  seq.size(), dcount, runlow);
      end else begin
         foreach (want[j]) begin
            n_checks++;
            if (seq[j] !== want[j]) begin
               n_err++;
               $display("FAIL wrap_seq idx=%0d got=%h want=%h", j, seq[j], want[j]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(0, 0, 1, 8'h50);
      step(1, 0, 0, 8'h00);
      idle(10);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({t0, o0, r0, dn0, le0} !== 11'd0 || {t1, o1, r1} !== 9'd0) begin
         n_err++;
         $display("FAIL async_reset got=%h/%h want=000", obs(0), obs(1));
      end
      model_reset();
      #1 rst = 1'b1;
      step(1, 0, 0, 8'h00);
      idle(3);
      n_checks++;
      if (r0 !== 1'b0 || r1 !== 1'b0 || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL start_after_reset running=%b/%b want=0", r0, r1);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(0, 0, 1, 8'h09);
      step(1, 0, 0, 8'h00);
      idle(2);
      step(0, 1, 0, 8'h00);
      step(1, 1, 0, 8'h00);
      n_checks++;
      if (r0 !== 1'b1 || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL pause_start_both_in_pause running=%b want=1", r0);
      end
      step(1, 1, 0, 8'h00);
      n_checks++;
      if (r0 !== 1'b0 || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL pause_start_both_in_run running=%b want=0", r0);
      end
      do_reset();
      step(1, 0, 1, 8'h07);
      idle(1);
      n_checks++;
      if ({t0, o0, r0} !== {8'h07, 1'b0} || obs(0) !== expv(0)) begin
         n_err++;
         $display("FAIL load_over_start got q=%h%h run=%b want q=07 run=0", t0, o0, r0);
      end
   endtask

   task automatic test_random();
      logic       s, p, l;
      logic [7:0] lv;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         s  = ($urandom_range(0, 3) == 0);
         p  = ($urandom_range(0, 9) == 0);
         l  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0) lv = 8'($urandom);
         else lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         step(s, p, l, lv);
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
               n_err++;
               $display("FAIL random dut%0d k=%0d got=%h want=%h", i, k, obs(i), expv(i));
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_countdown();
      test_load_err();
      test_pause();
      test_wrap();
      test_async_reset();
      test_simultaneous();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
